// File: rtl/min3_window_reducer.sv
// Two-level minimum search over four masked lanes per beat, followed by a
// running minimum across a fixed window of beats with a one-cycle result trigger.
module min3_window_reducer #(
    parameter int BEATS_PER_WINDOW = 64,
    parameter int VAL_W            = 14,
    parameter int IDX_W            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4*VAL_W-1:0]   in_values,
    input  logic [3:0]           in_lane_mask,
    input  logic [IDX_W-1:0]     in_base_index,
    output logic                 out_trigger,
    output logic [IDX_W-1:0]     out_min_index,
    output logic [VAL_W-1:0]     out_min_value,
    output logic                 out_none,
    output logic                 busy
);

    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_WINDOW - 1);
    localparam logic [VAL_W-1:0] VAL_NONE = {VAL_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_NONE = {IDX_W{1'b1}};

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [IDX_W-1:0] idx;
        logic             vld;
    } cand_t;

    localparam cand_t CAND_NULL = '{val: VAL_NONE, idx: IDX_NONE, vld: 1'b0};

    // A valid candidate beats an invalid one; ties keep the first operand.
    function automatic cand_t pick_min(input cand_t a, input cand_t b);
        cand_t w;
        if (a.vld != b.vld) begin
            w = a.vld ? a : b;
        end else if (a.vld && (b.val < a.val)) begin
            w = b;
        end else begin
            w = a;
        end
        return w;
    endfunction

    cand_t [3:0]       lane_s;
    cand_t             pair0_r;
    cand_t             pair1_r;
    cand_t             best_b_r;
    cand_t             acc_r;
    logic              a_beat_r;
    logic              b_beat_r;
    logic              c_beat_r;
    logic              c_last_r;
    logic              acc_take_s;
    logic [CNT_W-1:0]  cnt_r;

    // Lane unpacking: masked lanes become invalid worst-case candidates.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_s[i].idx = in_base_index + IDX_W'(i);
            lane_s[i].vld = in_lane_mask[i];
            if (in_lane_mask[i]) begin
                lane_s[i].val = in_values[i*VAL_W +: VAL_W];
            end else begin
                lane_s[i].val = VAL_NONE;
            end
        end
    end

    // Stage A: lane 0 vs 1 and lane 2 vs 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_beat_r <= 1'b0;
            pair0_r  <= CAND_NULL;
            pair1_r  <= CAND_NULL;
        end else begin
            a_beat_r <= in_valid;
            if (in_valid) begin
                pair0_r <= pick_min(lane_s[0], lane_s[1]);
                pair1_r <= pick_min(lane_s[2], lane_s[3]);
            end
        end
    end

    // Stage B: pair winners compared, pair 0/1 wins ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_beat_r <= 1'b0;
            best_b_r <= CAND_NULL;
        end else begin
            b_beat_r <= a_beat_r;
            if (a_beat_r) begin
                best_b_r <= pick_min(pair0_r, pair1_r);
            end
        end
    end

    // Accumulator update decision: first beat of a window always loads.
    always_comb begin
        acc_take_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
            acc_take_s = 1'b1;
        end else if (best_b_r.vld && (!acc_r.vld || (best_b_r.val < acc_r.val))) begin
            acc_take_s = 1'b1;
        end else begin
            acc_take_s = 1'b0;
        end
    end

    // Stage C: window beat counter and running minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_beat_r <= 1'b0;
            c_last_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
            acc_r    <= CAND_NULL;
        end else begin
            c_beat_r <= b_beat_r;
            c_last_r <= b_beat_r && (cnt_r == LAST_CNT);
            if (b_beat_r) begin
                cnt_r <= (cnt_r == LAST_CNT) ? CNT_ZERO : (cnt_r + CNT_ONE);
                if (acc_take_s) begin
                    acc_r <= best_b_r;
                end
            end
        end
    end

    // Result registers: the accumulator still holds the closed window here,
    // even if the next window's first beat loads it on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_trigger   <= 1'b0;
            out_none      <= 1'b0;
            out_min_value <= {VAL_W{1'b0}};
            out_min_index <= {IDX_W{1'b0}};
        end else if (c_last_r) begin
            out_trigger   <= 1'b1;
            out_none      <= ~acc_r.vld;
            out_min_value <= acc_r.vld ? acc_r.val : VAL_NONE;
            out_min_index <= acc_r.vld ? acc_r.idx : IDX_NONE;
        end else begin
            out_trigger   <= 1'b0;
            out_none      <= 1'b0;
        end
    end

    assign busy = a_beat_r | b_beat_r | c_beat_r | (cnt_r != CNT_ZERO);

endmodule
